// File: rtl/mb_controlo.sv
// mb_controlo: ATM-style session controller.
// A card insert (EN rising) opens a session that loads the account balance,
// asks for a PIN (blocking the card after MAX_TENT wrong tries), then serves
// balance enquiries, withdrawals and deposits from a menu until the card is
// removed, the user exits, or the idle timer expires. Every output is a flop.
//
// Strobe semantics: PIN_V and COD_V are single-cycle valid pulses with no
// ready/back-pressure. A strobe is accepted only in the state that consumes it
// (PIN_V in ESPERA_PIN, COD_V in MENU) and only while EN=1; otherwise it is
// dropped. EN=0 always wins over a strobe in the same cycle.
module mb_controlo #(
    parameter logic [3:0] PIN_REF  = 4'b0101,
    parameter int         MAX_TENT = 3,
    parameter int         T_LIM    = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] PIN,
    input  logic       PIN_V,
    input  logic [1:0] COD,
    input  logic       COD_V,
    input  logic [3:0] VAL,
    input  logic [3:0] SALDO,
    output logic [1:0] COD_OUT,
    output logic [3:0] VAL_OUT,
    output logic [3:0] SALDO_OUT,
    output logic [4:0] ECRA,
    output logic       PAR,
    output logic       BLOQ
);

    localparam int TENT_W  = (MAX_TENT < 2) ? 1 : $clog2(MAX_TENT + 1);
    localparam int TIMER_W = (T_LIM < 2) ? 1 : $clog2(T_LIM + 1);

    // Last values before the counters trip; comparing against these avoids
    // any overflow of the narrow counters.
    localparam logic [TENT_W-1:0]  TENT_LAST  = TENT_W'(MAX_TENT - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(T_LIM - 1);

    // One-hot screen codes
    localparam logic [4:0] SCR_IDLE    = 5'b00001;
    localparam logic [4:0] SCR_PIN     = 5'b00010;
    localparam logic [4:0] SCR_MENU    = 5'b00100;
    localparam logic [4:0] SCR_EXEC    = 5'b01000;
    localparam logic [4:0] SCR_NOFUNDS = 5'b01001;
    localparam logic [4:0] SCR_BLOQ    = 5'b10000;

    localparam logic [1:0] OP_CONSULTA = 2'b00;
    localparam logic [1:0] OP_LEVANTA  = 2'b01;
    localparam logic [1:0] OP_DEPOSITO = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ESPERA_PIN = 3'd1,
        ST_MENU       = 3'd2,
        ST_EXEC       = 3'd3,
        ST_FIM        = 3'd4,
        ST_BLOQUEADO  = 3'd5
    } state_t;

    state_t              state_q;
    logic                armed_q;      // EN has been seen low since reset / last insert
    logic [TENT_W-1:0]   tent_q;       // wrong-PIN attempts in this session
    logic [TIMER_W-1:0]  timer_q;      // idle cycles in ESPERA_PIN / MENU
    logic [1:0]          op_cod_q;     // operation latched from the menu
    logic [3:0]          op_val_q;     // amount latched from the menu
    logic [1:0]          cod_out_q;
    logic [3:0]          val_out_q;
    logic [3:0]          saldo_out_q;  // doubles as the session balance
    logic [4:0]          ecra_q;
    logic                par_q;
    logic                bloq_q;

    logic                pin_ok;
    logic                wd_ok;
    logic [3:0]          wd_saldo_d;
    logic [4:0]          dep_sum;
    logic [3:0]          dep_saldo_d;
    logic [3:0]          dep_cred_d;
    logic                tent_last;
    logic                timer_last;

    // Operation arithmetic on the latched request and the current session balance
    always_comb begin
        pin_ok      = (PIN == PIN_REF);
        wd_ok       = (op_val_q <= saldo_out_q);
        wd_saldo_d  = saldo_out_q - op_val_q;
        dep_sum     = {1'b0, saldo_out_q} + {1'b0, op_val_q};
        dep_saldo_d = dep_sum[4] ? 4'hF : dep_sum[3:0];
        // Amount really credited once the balance saturates
        dep_cred_d  = dep_saldo_d - saldo_out_q;
        tent_last   = (tent_q == TENT_LAST);
        timer_last  = (timer_q == TIMER_LAST);
    end

    // Session FSM with counters, operation latch and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            tent_q      <= '0;
            timer_q     <= '0;
            op_cod_q    <= 2'b00;
            op_val_q    <= 4'h0;
            cod_out_q   <= 2'b00;
            val_out_q   <= 4'h0;
            saldo_out_q <= 4'h0;
            ecra_q      <= SCR_IDLE;
            par_q       <= 1'b0;
            bloq_q      <= 1'b0;
        end else if (!EN) begin
            // Card absent: drop the session from any state, including BLOQUEADO.
            // Seeing EN low also arms the next insert.
            armed_q     <= 1'b1;
            state_q     <= ST_IDLE;
            ecra_q      <= SCR_IDLE;
            tent_q      <= '0;
            timer_q     <= '0;
            saldo_out_q <= 4'h0;
            par_q       <= 1'b0;
            bloq_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A fresh insert needs EN to have been low since the last one
                    if (armed_q) begin
                        armed_q     <= 1'b0;
                        state_q     <= ST_ESPERA_PIN;
                        ecra_q      <= SCR_PIN;
                        tent_q      <= '0;
                        timer_q     <= '0;
                        saldo_out_q <= SALDO;
                        par_q       <= ^SALDO;
                    end
                end

                ST_ESPERA_PIN: begin
                    if (PIN_V) begin
                        timer_q <= '0;
                        if (pin_ok) begin
                            state_q <= ST_MENU;
                            ecra_q  <= SCR_MENU;
                            tent_q  <= '0;
                        end else begin
                            tent_q <= tent_q + 1'b1;
                            if (tent_last) begin
                                state_q <= ST_BLOQUEADO;
                                ecra_q  <= SCR_BLOQ;
                                bloq_q  <= 1'b1;
                            end
                        end
                    end else if (timer_last) begin
                        state_q     <= ST_IDLE;
                        ecra_q      <= SCR_IDLE;
                        timer_q     <= '0;
                        saldo_out_q <= 4'h0;
                        par_q       <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_MENU: begin
                    if (COD_V) begin
                        op_cod_q <= COD;
                        op_val_q <= VAL;
                        state_q  <= ST_EXEC;
                        ecra_q   <= SCR_EXEC;
                        timer_q  <= '0;
                    end else if (timer_last) begin
                        state_q     <= ST_IDLE;
                        ecra_q      <= SCR_IDLE;
                        timer_q     <= '0;
                        saldo_out_q <= 4'h0;
                        par_q       <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_EXEC: begin
                    cod_out_q <= op_cod_q;
                    state_q   <= ST_FIM;
                    ecra_q    <= SCR_EXEC;
                    case (op_cod_q)
                        OP_CONSULTA: begin
                            val_out_q <= 4'h0;
                        end
                        OP_LEVANTA: begin
                            if (wd_ok) begin
                                saldo_out_q <= wd_saldo_d;
                                par_q       <= ^wd_saldo_d;
                                val_out_q   <= op_val_q;
                            end else begin
                                val_out_q <= 4'h0;
                                ecra_q    <= SCR_NOFUNDS;
                            end
                        end
                        OP_DEPOSITO: begin
                            saldo_out_q <= dep_saldo_d;
                            par_q       <= ^dep_saldo_d;
                            val_out_q   <= dep_cred_d;
                        end
                        default: begin
                            // Exit: end the session straight away
                            val_out_q   <= 4'h0;
                            state_q     <= ST_IDLE;
                            ecra_q      <= SCR_IDLE;
                            saldo_out_q <= 4'h0;
                            par_q       <= 1'b0;
                        end
                    endcase
                end

                ST_FIM: begin
                    state_q <= ST_MENU;
                    ecra_q  <= SCR_MENU;
                    timer_q <= '0;
                end

                ST_BLOQUEADO: begin
                    // Held until the card is removed (handled by the EN=0 branch)
                    bloq_q <= 1'b1;
                    ecra_q <= SCR_BLOQ;
                end

                default: begin
                    state_q <= ST_IDLE;
                    ecra_q  <= SCR_IDLE;
                end
            endcase
        end
    end

    assign COD_OUT   = cod_out_q;
    assign VAL_OUT   = val_out_q;
    assign SALDO_OUT = saldo_out_q;
    assign ECRA      = ecra_q;
    assign PAR       = par_q;
    assign BLOQ      = bloq_q;

endmodule

// File: tb/tb_mb_controlo.sv
// tb_mb_controlo: directed scenarios followed by randomized sessions, every
// cycle compared against a session-level reference model of the controller.
module tb_mb_controlo;

    localparam int M_IDLE  = 0;
    localparam int M_PIN   = 1;
    localparam int M_MENU  = 2;
    localparam int M_EXEC  = 3;
    localparam int M_FIM   = 4;
    localparam int M_BLOCK = 5;

    localparam int P_REF  = 5;
    localparam int P_TENT = 3;
    localparam int P_TLIM = 15;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [3:0] PIN;
    logic       PIN_V;
    logic [1:0] COD;
    logic       COD_V;
    logic [3:0] VAL;
    logic [3:0] SALDO;
    logic [1:0] COD_OUT;
    logic [3:0] VAL_OUT;
    logic [3:0] SALDO_OUT;
    logic [4:0] ECRA;
    logic       PAR;
    logic       BLOQ;

    int checks;
    int errors;

    // Reference model state
    int m_st;
    bit m_armed;
    int m_tries;
    int m_wait;
    int m_bal;
    int m_cod_out;
    int m_val_out;
    int p_cod;
    int p_val;
    bit m_insuf;

    mb_controlo dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .PIN       (PIN),
        .PIN_V     (PIN_V),
        .COD       (COD),
        .COD_V     (COD_V),
        .VAL       (VAL),
        .SALDO     (SALDO),
        .COD_OUT   (COD_OUT),
        .VAL_OUT   (VAL_OUT),
        .SALDO_OUT (SALDO_OUT),
        .ECRA      (ECRA),
        .PAR       (PAR),
        .BLOQ      (BLOQ)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_screen();
        case (m_st)
            M_IDLE:  return 8'h01;
            M_PIN:   return 8'h02;
            M_MENU:  return 8'h04;
            M_EXEC:  return 8'h08;
            M_FIM:   return m_insuf ? 8'h09 : 8'h08;
            default: return 8'h10;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cod_out"}, 8'(COD_OUT), 8'(m_cod_out));
        chk({tag, ".val_out"}, 8'(VAL_OUT), 8'(m_val_out));
        chk({tag, ".saldo_out"}, 8'(SALDO_OUT), 8'(m_bal));
        chk({tag, ".ecra"}, 8'(ECRA), exp_screen());
        chk({tag, ".par"}, 8'(PAR), 8'($countones(4'(m_bal)) % 2));
        chk({tag, ".bloq"}, 8'(BLOQ), 8'(m_st == M_BLOCK));
    endtask

    task automatic model_reset();
        m_st      = M_IDLE;
        m_armed   = 1'b0;
        m_tries   = 0;
        m_wait    = 0;
        m_bal     = 0;
        m_cod_out = 0;
        m_val_out = 0;
        m_insuf   = 1'b0;
    endtask

    // One clock of session behaviour, stated from the controller's rules
    task automatic model_step(input logic en, input logic [3:0] pin, input logic pv,
                              input logic [1:0] cod, input logic cv, input logic [3:0] val,
                              input logic [3:0] sal);
        int nxt;
        int credit;
        nxt     = m_st;
        m_insuf = 1'b0;
        if (!en) begin
            m_armed = 1'b1;
            nxt     = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (m_armed) begin
                        nxt     = M_PIN;
                        m_bal   = int'(sal);
                        m_tries = 0;
                        m_armed = 1'b0;
                    end
                end
                M_PIN: begin
                    if (pv) begin
                        if (int'(pin) == P_REF) begin
                            nxt     = M_MENU;
                            m_tries = 0;
                        end else begin
                            m_tries++;
                            if (m_tries >= P_TENT) nxt = M_BLOCK;
                        end
                        m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait >= P_TLIM) nxt = M_IDLE;
                    end
                end
                M_MENU: begin
                    if (cv) begin
                        p_cod  = int'(cod);
                        p_val  = int'(val);
                        nxt    = M_EXEC;
                        m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait >= P_TLIM) nxt = M_IDLE;
                    end
                end
                M_EXEC: begin
                    m_cod_out = p_cod;
                    nxt       = M_FIM;
                    case (p_cod)
                        0: m_val_out = 0;
                        1: begin
                            if (p_val <= m_bal) begin
                                m_bal     = m_bal - p_val;
                                m_val_out = p_val;
                            end else begin
                                m_val_out = 0;
                                m_insuf   = 1'b1;
                            end
                        end
                        2: begin
                            credit    = (p_val < 15 - m_bal) ? p_val : 15 - m_bal;
                            m_bal     = m_bal + credit;
                            m_val_out = credit;
                        end
                        default: begin
                            m_val_out = 0;
                            nxt       = M_IDLE;
                        end
                    endcase
                end
                M_FIM: nxt = M_MENU;
                default: ;
            endcase
        end
        if (nxt != m_st) m_wait = 0;
        if (nxt == M_IDLE) m_bal = 0;
        m_st = nxt;
    endtask

    // Driver: apply inputs, advance one clock, update model, compare after the edge
    task automatic step(input string tag, input logic en, input logic [3:0] pin, input logic pv,
                        input logic [1:0] cod, input logic cv, input logic [3:0] val,
                        input logic [3:0] sal);
        EN    = en;
        PIN   = pin;
        PIN_V = pv;
        COD   = cod;
        COD_V = cv;
        VAL   = val;
        SALDO = sal;
        @(posedge CLK);
        model_step(en, pin, pv, cod, cv, val, sal);
        #1;
        check_all(tag);
    endtask

    task automatic idle_step(input string tag, input logic en);
        step(tag, en, 4'h0, 1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic insert(input string tag, input logic [3:0] sal);
        step(tag, 1'b1, 4'h0, 1'b0, 2'b00, 1'b0, 4'h0, sal);
    endtask

    task automatic pin_step(input string tag, input logic [3:0] pin);
        step(tag, 1'b1, pin, 1'b1, 2'b00, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic op_step(input string tag, input logic [1:0] cod, input logic [3:0] val);
        step(tag, 1'b1, 4'h0, 1'b0, cod, 1'b1, val, 4'h0);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic pulse_reset(input string tag);
        RST = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        EN     = 1'b0;
        PIN    = 4'h0;
        PIN_V  = 1'b0;
        COD    = 2'b00;
        COD_V  = 1'b0;
        VAL    = 4'h0;
        SALDO  = 4'h0;
        #2;
        model_reset();
        check_all("reset");
        #1;
        RST = 1'b0;

        // EN already high at reset release: no session may start
        idle_step("no_edge0", 1'b1);
        idle_step("no_edge1", 1'b1);
        chk("no_edge_ecra", 8'(ECRA), 8'h01);

        // Withdraw 1 from a full balance
        idle_step("arm", 1'b0);
        insert("w_insert", 4'hF);
        chk("w_insert_ecra", 8'(ECRA), 8'h02);
        pin_step("w_pin", 4'b0101);
        chk("w_pin_ecra", 8'(ECRA), 8'h04);
        op_step("w_op", 2'b01, 4'h1);
        chk("w_exec_ecra", 8'(ECRA), 8'h08);
        idle_step("w_fim", 1'b1);
        chk("w_saldo", 8'(SALDO_OUT), 8'hE);
        chk("w_val", 8'(VAL_OUT), 8'h1);
        chk("w_par", 8'(PAR), 8'h1);
        idle_step("w_menu", 1'b1);
        chk("w_menu_ecra", 8'(ECRA), 8'h04);
        idle_step("w_out", 1'b0);
        chk("w_out_saldo", 8'(SALDO_OUT), 8'h0);

        // Deposit saturating at F
        insert("d_insert", 4'hE);
        pin_step("d_pin", 4'b0101);
        op_step("d_op", 2'b10, 4'h3);
        idle_step("d_fim", 1'b1);
        chk("d_saldo", 8'(SALDO_OUT), 8'hF);
        chk("d_val", 8'(VAL_OUT), 8'h1);
        idle_step("d_menu", 1'b1);
        idle_step("d_out", 1'b0);

        // Insufficient funds, then exit with card still present
        insert("n_insert", 4'h3);
        pin_step("n_pin", 4'b0101);
        op_step("n_op", 2'b01, 4'h5);
        idle_step("n_fim", 1'b1);
        chk("n_ecra", 8'(ECRA), 8'h09);
        chk("n_saldo", 8'(SALDO_OUT), 8'h3);
        chk("n_val", 8'(VAL_OUT), 8'h0);
        idle_step("n_menu", 1'b1);
        chk("n_menu_ecra", 8'(ECRA), 8'h04);
        op_step("x_op", 2'b11, 4'h7);
        idle_step("x_exit", 1'b1);
        chk("x_ecra", 8'(ECRA), 8'h01);
        idle_step("x_stay", 1'b1);
        chk("x_stay_ecra", 8'(ECRA), 8'h01);
        idle_step("x_out", 1'b0);

        // Three wrong PINs block the card until removal
        insert("b_insert", 4'h7);
        pin_step("b_pin0", 4'b0000);
        pin_step("b_pin1", 4'b0000);
        pin_step("b_pin2", 4'b0000);
        chk("b_bloq", 8'(BLOQ), 8'h1);
        chk("b_ecra", 8'(ECRA), 8'h10);
        pin_step("b_pin_ok_ignored", 4'b0101);
        idle_step("b_out", 1'b0);
        chk("b_out_bloq", 8'(BLOQ), 8'h0);
        chk("b_out_ecra", 8'(ECRA), 8'h01);

        // Menu timeout after T_LIM idle cycles
        insert("t_insert", 4'h9);
        pin_step("t_pin", 4'b0101);
        for (int i = 0; i < P_TLIM - 1; i++) idle_step("t_wait", 1'b1);
        chk("t_before_ecra", 8'(ECRA), 8'h04);
        idle_step("t_expire", 1'b1);
        chk("t_ecra", 8'(ECRA), 8'h01);
        chk("t_saldo", 8'(SALDO_OUT), 8'h0);
        idle_step("t_out", 1'b0);

        // Card removed in the same cycle as an operation strobe
        insert("e_insert", 4'h8);
        pin_step("e_pin", 4'b0101);
        step("e_drop", 1'b0, 4'h0, 1'b0, 2'b01, 1'b1, 4'h2, 4'h0);
        chk("e_ecra", 8'(ECRA), 8'h01);
        idle_step("e_after", 1'b0);
        chk("e_saldo", 8'(SALDO_OUT), 8'h0);

        // Reset in the middle of EXEC
        insert("r_insert", 4'h4);
        pin_step("r_pin", 4'b0101);
        op_step("r_op", 2'b10, 4'h2);
        pulse_reset("r_reset");
        chk("r_ecra", 8'(ECRA), 8'h01);
        chk("r_cod", 8'(COD_OUT), 8'h0);
        for (int i = 0; i < 3; i++) idle_step("r_hold", 1'b1);
        chk("r_hold_ecra", 8'(ECRA), 8'h01);

        // Randomized sessions
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                step("rnd",
                     ($urandom_range(0, 99) < 93),
                     ($urandom_range(0, 1) == 1) ? 4'b0101 : 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 99) < 25),
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 99) < 25),
                     4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mb_controlo.md
MB_CONTROLO -- requirements
Module: mb_controlo

Interface
REQ-001 Parameters SHALL be:
- PIN_REF, default 4'b0101, reference PIN.
- MAX_TENT, default 3, wrong-PIN attempts before block.
- T_LIM, default 15, idle-cycle timeout.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  card present (level).
- PIN  in  4  entered PIN.
- PIN_V  in  1  PIN strobe, 1 cycle.
- COD  in  2  operation: 00 consulta, 01 levantamento, 10 deposito, 11 sair.
- COD_V  in  1  operation strobe, 1 cycle.
- VAL  in  4  amount for 01/10.
- SALDO  in  4  account balance, sampled at card insert.
- COD_OUT  out  2  last executed operation.
- VAL_OUT  out  4  amount dispensed or accepted.
- SALDO_OUT  out  4  current session balance.
- ECRA  out  5  screen code, one-hot.
- PAR  out  1  even parity of SALDO_OUT.
- BLOQ  out  1  card blocked.

Function
REQ-003 The FSM SHALL have six states: IDLE, ESPERA_PIN, MENU, EXEC, FIM, BLOQUEADO.
REQ-004 ECRA SHALL be registered and SHALL read:
- IDLE 00001, ESPERA_PIN 00010, MENU 00100, EXEC/FIM 01000, BLOQUEADO 10000.
REQ-005 IDLE->ESPERA_PIN SHALL occur on the first cycle EN=1. That cycle SHALL load the SALDO register from SALDO and clear the attempt counter and the timer.
REQ-006 In ESPERA_PIN, PIN_V=1 with PIN==PIN_REF SHALL go to MENU next cycle and clear the attempt counter.
REQ-007 In ESPERA_PIN, PIN_V=1 with PIN!=PIN_REF SHALL increment the attempt counter. When the count reaches MAX_TENT, the FSM SHALL go to BLOQUEADO; otherwise it SHALL stay in ESPERA_PIN.
REQ-008 In MENU, COD_V=1 SHALL latch COD and VAL and go to EXEC. COD_V outside MENU SHALL be ignored.
REQ-009 EXEC SHALL last exactly one cycle and then go to FIM. Per operation:
- 00: SALDO_OUT unchanged, VAL_OUT=0.
- 01: if VAL<=saldo, saldo-=VAL and VAL_OUT=VAL; else saldo unchanged, VAL_OUT=0, ECRA=01001 for the FIM cycle (insufficient funds).
- 10: saldo+=VAL, saturating at 4'hF; VAL_OUT = amount actually credited.
- 11: go directly to IDLE; VAL_OUT=0.
REQ-010 FIM SHALL last one cycle and then return to MENU. COD_OUT, VAL_OUT and SALDO_OUT SHALL hold until the next EXEC.
REQ-011 BLOQ SHALL be 1 in BLOQUEADO. BLOQUEADO SHALL go to IDLE only when EN=0, keeping BLOQ=1 until then.
REQ-012 EN=0 in any state other than BLOQUEADO SHALL force IDLE on the next edge, abandoning any pending operation. EN has priority over PIN_V and COD_V in the same cycle.
REQ-013 The timer SHALL count cycles in ESPERA_PIN and MENU with no strobe, and SHALL reset on any accepted strobe or state change. Reaching T_LIM SHALL force IDLE.
REQ-014 PAR SHALL equal the XOR-reduction of SALDO_OUT, updated in the same cycle as SALDO_OUT.
REQ-015 All outputs SHALL be registered. Latency from strobe to output update SHALL be 1 cycle for the ECRA state change and 2 cycles for SALDO_OUT/VAL_OUT.
REQ-016 In IDLE, SALDO_OUT SHALL be 0 and the session balance SHALL be discarded.

Reset
REQ-017 RST=1 SHALL immediately (asynchronously) force IDLE with these outputs:
- COD_OUT=00, VAL_OUT=0, SALDO_OUT=0, ECRA=00001, PAR=0, BLOQ=0.
- attempt counter and timer = 0.
REQ-018 RST asserted mid-session SHALL abort it. After release, the FSM SHALL require a new EN rising edge, i.e. EN must be seen low once before leaving IDLE.

Verification
REQ-019 EN=1, SALDO=4'hF, PIN=0101 strobe, COD=01 VAL=0001 strobe -> SALDO_OUT=1110, VAL_OUT=0001, PAR=1, ECRA MENU after FIM.
REQ-020 Three PIN strobes of 0000 -> BLOQ=1, ECRA=10000; EN=0 -> IDLE, BLOQ=0.
REQ-021 SALDO=0011, COD=01 VAL=0101 -> SALDO_OUT=0011, VAL_OUT=0, ECRA=01001 for one cycle.
REQ-022 SALDO=1110, COD=10 VAL=0011 -> SALDO_OUT=1111, VAL_OUT=0001.
REQ-023 Idle in MENU for 15 cycles -> IDLE, SALDO_OUT=0. Separately, EN=0 on the same cycle as COD_V -> IDLE, no operation executed.
REQ-024 RST pulse during EXEC -> all outputs at reset values within the same cycle. Holding EN=1 after release -> FSM stays in IDLE.
